esposito_seq_multiplier: RTL
============================

# esposito_seq_multiplier

Multi-cycle unsigned approximate multiplier controller that shares one bank of 4:2 column compressors across all partial-product rows. Each cycle it reduces two partial-product rows into a carry-save accumulator. Low-order columns use the Esposito approximate 4:2 compressor and high columns use exact carry-save addition. A single exact final add produces the product. It sits between an upstream operand source and a downstream consumer, using valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: operand width; even, ≥ 4.
- APPROX_COLS, 4: number of low product columns (0 … 2*WIDTH) reduced with the approximate compressor.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand, unsigned.
- in_b  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2*WIDTH  product.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, REDUCE, ADD, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: latch A=in_a and B=in_b, clear S=C=0 (each 2*WIDTH bits), clear step counter k=0, go to REDUCE.
- REDUCE
  - Step k forms PPe = (A & {WIDTH{B[2k]}}) << 2k and PPo = (A & {WIDTH{B[2k+1]}}) << (2k+1), zero-extended to 2*WIDTH.
  - Columns j < APPROX_COLS, with x1=S[j], x2=C[j], x3=PPe[j], x4=PPo[j]:
    - S'[j] = (x1&x2)|x3|x4.
    - C'[j] = (x3&x4)|x1|x2.
    - Both outputs have weight 2^j. No carry leaves the approximate region.
  - Columns ≥ APPROX_COLS: exact 4:2 carry-save with S'_hi + C'_hi ≡ S_hi + C_hi + PPe_hi + PPo_hi (mod 2^(2*WIDTH)). The internal bit split is free; only the final sum is checked.
  - k increments each cycle. After step k = WIDTH/2-1, go to ADD.
- ADD: out_p <= (S + C) mod 2^(2*WIDTH), exact; out_valid <= 1; go to DONE.
- DONE
  - out_p and out_valid are held stable.
  - On out_valid&out_ready: out_valid <= 0, go to IDLE.
- in_valid is ignored outside IDLE. Input values are don't-care while in_valid=0.
- APPROX_COLS=0 gives exact products. APPROX_COLS ≥ 2*WIDTH makes every column approximate.

## Timing
- Reset values: in_ready=1, out_valid=0, out_p=0, busy=0; state IDLE; S, C, k cleared.
- rst during any state aborts the operation at that edge. The pending product is lost, and rst has priority over all handshakes.
- Latency: operands accepted at edge E0; reduction steps at edges E1 … E(WIDTH/2); out_valid rises after edge E(WIDTH/2+1). For WIDTH=8, out_valid is high 5 cycles after acceptance.
- in_ready is combinational from state (IDLE only). It is low from the cycle after acceptance until the cycle after the output handshake.
- Minimum issue interval is WIDTH/2+3 cycles with out_ready held high.
- out_valid stays high with out_ready low for any number of cycles; out_p does not change.

## Configuration
- ESP_RUNTIME_MODE_EN defined:
  - Adds input port approx_mode (1 bit), sampled only at operand acceptance.
  - Latched approx_mode=0 makes that operation fully exact (effective APPROX_COLS=0).
  - Latched approx_mode=1 uses APPROX_COLS.
- Not defined: no approx_mode port; APPROX_COLS always applies.

## Test plan
- Reset then idle, WIDTH=8: assert rst 2 cycles -> in_ready=1, out_valid=0, out_p=0, busy=0.
- Exact path, APPROX_COLS=0: a=200, b=150 -> out_p=30000 with out_valid exactly 5 cycles after acceptance; a=15, b=15 -> 225.
- Approximate path, APPROX_COLS=4: a=15, b=15 -> out_p=205 (error −20); a=3, b=3 -> 9; a=1, b=3 -> 3; a=0, b=255 -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_p stable, in_ready=0, and a new in_valid is ignored; release -> IDLE next cycle, then the next operand pair is accepted.
- Reset mid-operation: assert rst at step k=2 -> all outputs return to reset values next cycle; the following transaction a=255, b=255 with APPROX_COLS=0 -> 65025.
- ESP_RUNTIME_MODE_EN, APPROX_COLS=4: a=15, b=15, approx_mode=0 -> 225; approx_mode=1 -> 205; toggling approx_mode mid-operation has no effect.

Source files
------------

// File: rtl/esposito_seq_multiplier.sv
// esposito_seq_multiplier
//
// Multi-cycle unsigned approximate multiplier. Two partial-product rows are
// folded into a carry-save accumulator (s_acc, c_acc) per cycle. Columns below
// APPROX_COLS use the Esposito approximate 4:2 compressor; the remaining
// columns use exact carry-save addition. One exact add then forms the product.
//
// Optional feature macro: ESP_RUNTIME_MODE_EN
//   Adds the approx_mode input, latched at operand acceptance. A latched 0
//   makes that operation fully exact; a latched 1 uses APPROX_COLS.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     operand pair valid
//   in_ready     block can accept operands (IDLE only)
//   in_a, in_b   unsigned multiplicand / multiplier, WIDTH bits
//   out_valid    product valid
//   out_ready    consumer accepts the product
//   out_p        product, 2*WIDTH bits
//   busy         high in any state other than IDLE
//   approx_mode  (ESP_RUNTIME_MODE_EN only) per-operation approximation enable

module esposito_seq_multiplier #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
`ifdef ESP_RUNTIME_MODE_EN
    ,
    input  logic                 approx_mode
`endif
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned KW    = $clog2(STEPS + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StReduce = 2'd1;
    localparam logic [1:0] StAdd    = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // One bit per product column: set where the approximate compressor applies.
    function automatic logic [PW-1:0] build_mask();
        logic [PW-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < PW; j++) begin
            m[j] = (j < APPROX_COLS);
        end
        return m;
    endfunction

    localparam logic [PW-1:0] ApproxMask = build_mask();

    logic [1:0]       state;
    logic [PW-1:0]    mcand;   // multiplicand, pre-shifted to the current row pair
    logic [WIDTH-1:0] mplier;  // multiplier, shifted so bits [1:0] select the rows
    logic [PW-1:0]    s_acc;
    logic [PW-1:0]    c_acc;
    logic [KW-1:0]    k;

    logic [PW-1:0]    mask;

`ifdef ESP_RUNTIME_MODE_EN
    logic             mode_q;
    assign mask = mode_q ? ApproxMask : '0;
`else
    assign mask = ApproxMask;
`endif

    // Partial-product rows for this step.
    logic [PW-1:0] pp_e;
    logic [PW-1:0] pp_o;
    logic [PW-1:0] lo_s, lo_c;
    logic [PW-1:0] x1, x2, x3, x4;
    logic [PW-1:0] sum1, cy1, sum2, cy2;
    logic [PW-1:0] s_next, c_next;

    always_comb begin
        pp_e = mplier[0] ? mcand : '0;
        pp_o = mplier[1] ? (mcand << 1) : '0;

        // Approximate region: both outputs keep the column weight, no carry out.
        lo_s = ((s_acc & c_acc) | pp_e | pp_o) & mask;
        lo_c = ((pp_e & pp_o) | s_acc | c_acc) & mask;

        // Exact region: two cascaded 3:2 layers. Inputs are zero below the
        // boundary, so no carries ever land in the approximate columns.
        x1   = s_acc & ~mask;
        x2   = c_acc & ~mask;
        x3   = pp_e  & ~mask;
        x4   = pp_o  & ~mask;
        sum1 = x1 ^ x2 ^ x3;
        cy1  = ((x1 & x2) | (x1 & x3) | (x2 & x3)) << 1;
        sum2 = sum1 ^ cy1 ^ x4;
        cy2  = ((sum1 & cy1) | (sum1 & x4) | (cy1 & x4)) << 1;

        s_next = lo_s | sum2;
        c_next = lo_c | cy2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            mcand     <= '0;
            mplier    <= '0;
            s_acc     <= '0;
            c_acc     <= '0;
            k         <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
`ifdef ESP_RUNTIME_MODE_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, in_a};
                        mplier <= in_b;
                        s_acc  <= '0;
                        c_acc  <= '0;
                        k      <= '0;
`ifdef ESP_RUNTIME_MODE_EN
                        mode_q <= approx_mode;
`endif
                        state  <= StReduce;
                    end
                end
                StReduce: begin
                    s_acc  <= s_next;
                    c_acc  <= c_next;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    k      <= k + KW'(1);
                    if (k == KW'(STEPS - 1)) begin
                        state <= StAdd;
                    end
                end
                StAdd: begin
                    out_p     <= s_acc + c_acc;
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);

endmodule
